cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: DATAW, 16, width of a broadcast data word.
REQ-002 Parameter: TAGW, 4, width of the reservation-station tag; tag 0 means "no dependency" and is reserved.
REQ-003 Port: CLK  in  1  clock, rising edge; reset CLR, asynchronous, active-high.
REQ-004 Port: CLR  in  1  asynchronous active-high reset.
REQ-005 Port: req[2:0]  in  3  per-unit request: 0=add/sub, 1=mul/div, 2=load; held high until acked.
REQ-006 Port: tag0/tag1/tag2  in  TAGW each  producing-station tag per unit.
REQ-007 Port: data0/data1/data2  in  DATAW each  result per unit.
REQ-008 Port: dest0/dest1/dest2  in  3 each  destination register number per unit.
REQ-009 Port: stall  in  1  suppresses new grants while high.
REQ-010 Port: ack[2:0]  out  3  one-cycle registered grant pulse per unit.
REQ-011 Port: cdb_valid  out  1  broadcast valid, one cycle per grant.
REQ-012 Port: cdb_tag / cdb_data / cdb_dest  out  TAGW / DATAW / 3  broadcast fields; drive register file depW/dataW/numW and wren=cdb_valid.
REQ-013 Port: tag_err  out  1  sticky flag, set when a request carrying tag 0 is observed.
REQ-014 Port: bcast_cnt  out  16  count of completed broadcasts.

Function
REQ-015 The block SHALL grant at most one requester per cycle; all outputs SHALL be registered.
REQ-016 Eligible(k) = req[k] & ~ack[k] & (tag_k != 0) & ~stall.
REQ-017 Masking with ~ack[k] SHALL prevent re-granting a unit in the cycle its ack is visible, before it can drop req.
REQ-018 Selection SHALL be round-robin from pointer ptr (2 bits, values 0..2): check ptr, ptr+1, ptr+2 mod 3; the first eligible unit wins.
REQ-019 On a grant to k at edge N: ack[k]=1, cdb_valid=1, and cdb_tag/data/dest = tag_k/data_k/dest_k sampled before edge N; ptr = (k+1) mod 3.
REQ-020 Latency SHALL be one cycle from req sampled high to ack/cdb_valid high.
REQ-021 With no eligible unit, ack=0 and cdb_valid=0, cdb_tag=0, cdb_dest and cdb_data hold, ptr unchanged.
REQ-022 ptr SHALL never take value 3; any wrap past 2 SHALL return to 0.
REQ-023 stall high SHALL force ack=0 and cdb_valid=0 on the next edge and freeze ptr; pending reqs SHALL be served after stall drops, in round-robin order.
REQ-024 A request with req[k]=1 and tag_k=0 SHALL never be granted and SHALL set tag_err until reset.
REQ-025 bcast_cnt SHALL increment by 1 on each edge that sets cdb_valid and SHALL wrap from 0xFFFF to 0.
REQ-026 With all three units requesting continuously (each re-raising req after ack), grants SHALL rotate 0,1,2,0,... with no unit skipped.

Reset
REQ-027 CLR high SHALL immediately clear ack, cdb_valid, cdb_tag, cdb_data, cdb_dest, tag_err, bcast_cnt, and ptr to 0, independent of CLK.
REQ-028 A grant in flight when CLR rises SHALL be discarded, with no ack; requesters SHALL keep req high and be served after reset.
REQ-029 The first grant after CLR falls SHALL favour unit 0.

Verification
REQ-030 Reset, then req=001, tag0=3, data0=0x00AA, dest0=5 -> next edge: ack=001, cdb_valid=1, cdb_tag=3, cdb_data=0x00AA, cdb_dest=5, bcast_cnt=1.
REQ-031 req=111 held with tags 1/2/3 and each unit dropping req one cycle after its ack -> ack sequence 001,010,100 on consecutive cycles, then cdb_valid=0.
REQ-032 req=010 held with no drop -> ack=010 on alternate cycles only, never two consecutive cycles.
REQ-033 req=101 and stall=1 for 4 cycles -> ack=000 and cdb_valid=0 throughout; stall drops -> ack=001, then 100.
REQ-034 req=100 with tag2=0 -> no ack; tag_err=1 from the next edge, persisting until CLR.
REQ-035 Preload bcast_cnt to 0xFFFF via 65535 grants, then one more grant -> bcast_cnt=0x0000; assert CLR mid-grant -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among add/sub, mul/div and load
// units, broadcasting the winner's tag/data/dest on registered outputs.
module cdb_arbiter #(
    parameter int DATAW = 16,
    parameter int TAGW  = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [2:0]       req,
    input  logic [TAGW-1:0]  tag0,
    input  logic [TAGW-1:0]  tag1,
    input  logic [TAGW-1:0]  tag2,
    input  logic [DATAW-1:0] data0,
    input  logic [DATAW-1:0] data1,
    input  logic [DATAW-1:0] data2,
    input  logic [2:0]       dest0,
    input  logic [2:0]       dest1,
    input  logic [2:0]       dest2,
    input  logic             stall,
    output logic [2:0]       ack,
    output logic             cdb_valid,
    output logic [TAGW-1:0]  cdb_tag,
    output logic [DATAW-1:0] cdb_data,
    output logic [2:0]       cdb_dest,
    output logic             tag_err,
    output logic [15:0]      bcast_cnt
);

    logic [TAGW-1:0]  tag_arr  [3];
    logic [DATAW-1:0] data_arr [3];
    logic [2:0]       dest_arr [3];

    assign tag_arr[0]  = tag0;
    assign tag_arr[1]  = tag1;
    assign tag_arr[2]  = tag2;
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;
    assign dest_arr[0] = dest0;
    assign dest_arr[1] = dest1;
    assign dest_arr[2] = dest2;

    logic [2:0] elig;
    logic [2:0] bad_req;

    // A unit whose ack is currently visible has not yet had a chance to drop req.
    for (genvar gi = 0; gi < 3; gi++) begin : g_unit
        assign elig[gi]    = req[gi] & ~ack[gi] & (tag_arr[gi] != '0) & ~stall;
        assign bad_req[gi] = req[gi] & (tag_arr[gi] == '0);
    end

    logic [1:0] ptr_reg;
    logic [1:0] ptr_next;
    logic       found;
    logic [1:0] sel;
    logic [2:0] pos;

    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        pos   = 3'd0;
        for (int i = 0; i < 3; i++) begin
            pos = {1'b0, ptr_reg} + 3'(i);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (!found && elig[pos[1:0]]) begin
                found = 1'b1;
                sel   = pos[1:0];
            end
        end
    end

    assign ptr_next = (sel == 2'd2) ? 2'd0 : sel + 2'd1;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ack       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_dest  <= '0;
            tag_err   <= 1'b0;
            bcast_cnt <= '0;
            ptr_reg   <= 2'd0;
        end else begin
            tag_err <= tag_err | (|bad_req);
            if (found) begin
                ack       <= 3'b001 << sel;
                cdb_valid <= 1'b1;
                cdb_tag   <= tag_arr[sel];
                cdb_data  <= data_arr[sel];
                cdb_dest  <= dest_arr[sel];
                bcast_cnt <= bcast_cnt + 16'd1;
                ptr_reg   <= ptr_next;
            end else begin
                // Data and dest hold so the register file sees stable fields when idle.
                ack       <= '0;
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, randomized run against a
// behavioural model, counter wrap and asynchronous reset mid-grant.
module tb_cdb_arbiter;

    localparam int DATAW = 16;
    localparam int TAGW  = 4;

    logic             CLK = 1'b0;
    logic             CLR = 1'b0;
    logic [2:0]       req = '0;
    logic [TAGW-1:0]  tag0 = '0, tag1 = '0, tag2 = '0;
    logic [DATAW-1:0] data0 = '0, data1 = '0, data2 = '0;
    logic [2:0]       dest0 = '0, dest1 = '0, dest2 = '0;
    logic             stall = 1'b0;
    logic [2:0]       ack;
    logic             cdb_valid;
    logic [TAGW-1:0]  cdb_tag;
    logic [DATAW-1:0] cdb_data;
    logic [2:0]       cdb_dest;
    logic             tag_err;
    logic [15:0]      bcast_cnt;

    cdb_arbiter #(.DATAW(DATAW), .TAGW(TAGW)) dut (
        .CLK(CLK), .CLR(CLR), .req(req),
        .tag0(tag0), .tag1(tag1), .tag2(tag2),
        .data0(data0), .data1(data1), .data2(data2),
        .dest0(dest0), .dest1(dest1), .dest2(dest2),
        .stall(stall), .ack(ack), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_dest(cdb_dest),
        .tag_err(tag_err), .bcast_cnt(bcast_cnt)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string pfx, input logic [2:0] e_ack, input logic e_valid,
                           input logic [TAGW-1:0] e_tag, input logic [DATAW-1:0] e_data,
                           input logic [2:0] e_dest, input logic e_err, input logic [15:0] e_cnt);
        chk({pfx, "_ack"},   32'(ack),       32'(e_ack));
        chk({pfx, "_valid"}, 32'(cdb_valid), 32'(e_valid));
        chk({pfx, "_tag"},   32'(cdb_tag),   32'(e_tag));
        chk({pfx, "_data"},  32'(cdb_data),  32'(e_data));
        chk({pfx, "_dest"},  32'(cdb_dest),  32'(e_dest));
        chk({pfx, "_err"},   32'(tag_err),   32'(e_err));
        chk({pfx, "_cnt"},   32'(bcast_cnt), 32'(e_cnt));
    endtask

    // Called at a negedge: asserts CLR off-edge, checks the async clear, releases at the next negedge.
    task automatic do_reset(input string pfx);
        CLR = 1'b1;
        #1;
        chk_all({pfx, "_rst"}, 3'b000, 1'b0, '0, '0, 3'd0, 1'b0, 16'd0);
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    typedef struct {
        bit               rst;
        logic [2:0]       rq;
        bit               st;
        logic [TAGW-1:0]  t0, t1, t2;
        logic [2:0]       e_ack;
        bit               e_valid;
        logic [TAGW-1:0]  e_tag;
        logic [DATAW-1:0] e_data;
        logic [2:0]       e_dest;
        bit               e_err;
        logic [15:0]      e_cnt;
    } vec_t;

    vec_t vt[$];

    // Behavioural model state.
    int               m_ptr;
    logic [2:0]       m_ack;
    logic             m_valid;
    logic [TAGW-1:0]  m_tag;
    logic [DATAW-1:0] m_data;
    logic [2:0]       m_dest;
    logic             m_err;
    logic [15:0]      m_cnt;

    task automatic model_reset();
        m_ptr = 0; m_ack = '0; m_valid = 0; m_tag = '0;
        m_data = '0; m_dest = '0; m_err = 0; m_cnt = '0;
    endtask

    // Next-edge outcome from the arbitration rules, evaluated on pre-edge inputs.
    task automatic model_step();
        logic [TAGW-1:0]  tg [3];
        logic [DATAW-1:0] dt [3];
        logic [2:0]       ds [3];
        int win;
        tg[0] = tag0;  tg[1] = tag1;  tg[2] = tag2;
        dt[0] = data0; dt[1] = data1; dt[2] = data2;
        ds[0] = dest0; ds[1] = dest1; ds[2] = dest2;
        win = -1;
        for (int i = 0; i < 3; i++) begin
            int k;
            k = (m_ptr + i) % 3;
            if (win < 0 && req[k] && !m_ack[k] && tg[k] != 0 && !stall) win = k;
        end
        for (int k = 0; k < 3; k++)
            if (req[k] && tg[k] == 0) m_err = 1'b1;
        if (win >= 0) begin
            m_ack = 3'(1 << win);
            m_valid = 1'b1;
            m_tag = tg[win];
            m_data = dt[win];
            m_dest = ds[win];
            m_ptr = (win + 1) % 3;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_ack = '0;
            m_valid = 1'b0;
            m_tag = '0;
        end
    endtask

    initial begin
        data0 = 16'h00AA; dest0 = 3'd5;
        data1 = 16'h1111; dest1 = 3'd6;
        data2 = 16'h2222; dest2 = 3'd7;

        // rst, req, stall, t0,t1,t2, ack, valid, tag, data, dest, err, cnt
        vt.push_back('{1, 3'b001, 0, 3, 2, 1, 3'b001, 1, 3, 16'h00AA, 5, 0, 1});
        vt.push_back('{0, 3'b000, 0, 3, 2, 1, 3'b000, 0, 0, 16'h00AA, 5, 0, 1});
        vt.push_back('{1, 3'b111, 0, 1, 2, 3, 3'b001, 1, 1, 16'h00AA, 5, 0, 1});
        vt.push_back('{0, 3'b110, 0, 1, 2, 3, 3'b010, 1, 2, 16'h1111, 6, 0, 2});
        vt.push_back('{0, 3'b100, 0, 1, 2, 3, 3'b100, 1, 3, 16'h2222, 7, 0, 3});
        vt.push_back('{0, 3'b000, 0, 1, 2, 3, 3'b000, 0, 0, 16'h2222, 7, 0, 3});
        vt.push_back('{1, 3'b010, 0, 1, 2, 3, 3'b010, 1, 2, 16'h1111, 6, 0, 1});
        vt.push_back('{0, 3'b010, 0, 1, 2, 3, 3'b000, 0, 0, 16'h1111, 6, 0, 1});
        vt.push_back('{0, 3'b010, 0, 1, 2, 3, 3'b010, 1, 2, 16'h1111, 6, 0, 2});
        vt.push_back('{0, 3'b010, 0, 1, 2, 3, 3'b000, 0, 0, 16'h1111, 6, 0, 2});
        vt.push_back('{1, 3'b101, 1, 1, 2, 3, 3'b000, 0, 0, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 3'b101, 1, 1, 2, 3, 3'b000, 0, 0, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 3'b101, 1, 1, 2, 3, 3'b000, 0, 0, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 3'b101, 1, 1, 2, 3, 3'b000, 0, 0, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 3'b101, 0, 1, 2, 3, 3'b001, 1, 1, 16'h00AA, 5, 0, 1});
        vt.push_back('{0, 3'b101, 0, 1, 2, 3, 3'b100, 1, 3, 16'h2222, 7, 0, 2});
        vt.push_back('{0, 3'b000, 0, 1, 2, 3, 3'b000, 0, 0, 16'h2222, 7, 0, 2});
        vt.push_back('{1, 3'b100, 0, 1, 2, 0, 3'b000, 0, 0, 16'h0000, 0, 1, 0});
        vt.push_back('{0, 3'b000, 0, 1, 2, 0, 3'b000, 0, 0, 16'h0000, 0, 1, 0});
        vt.push_back('{0, 3'b001, 0, 1, 2, 0, 3'b001, 1, 1, 16'h00AA, 5, 1, 1});

        @(negedge CLK);
        foreach (vt[i]) begin
            if (vt[i].rst) do_reset($sformatf("row%0d", i));
            req = vt[i].rq; stall = vt[i].st;
            tag0 = vt[i].t0; tag1 = vt[i].t1; tag2 = vt[i].t2;
            @(posedge CLK);
            @(negedge CLK);
            chk_all($sformatf("row%0d", i), vt[i].e_ack, vt[i].e_valid, vt[i].e_tag,
                    vt[i].e_data, vt[i].e_dest, vt[i].e_err, vt[i].e_cnt);
            $display("row %0d req=%b stall=%0d ack=%b valid=%0d tag=%0d cnt=%0d",
                     i, vt[i].rq, vt[i].st, ack, cdb_valid, cdb_tag, bcast_cnt);
        end

        // Randomized traffic against the model, with occasional resets.
        req = '0; stall = 0;
        do_reset("rand");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($sformatf("rand%0d", c));
                model_reset();
            end
            req   = 3'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            tag0  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tag1  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tag2  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            data0 = 16'($urandom); data1 = 16'($urandom); data2 = 16'($urandom);
            dest0 = 3'($urandom);  dest1 = 3'($urandom);  dest2 = 3'($urandom);
            model_step();
            @(posedge CLK);
            @(negedge CLK);
            chk_all($sformatf("rand%0d", c), m_ack, m_valid, m_tag, m_data, m_dest, m_err, m_cnt);
            if (c % 500 == 0)
                $display("rand %0d req=%b stall=%0d ack=%b cnt=%0d", c, req, stall, ack, bcast_cnt);
        end

        // Counter wrap with continuous requests, then reset in the middle of a grant.
        req = '0; stall = 0;
        data0 = 16'h00AA; dest0 = 3'd5; data1 = 16'h1111; dest1 = 3'd6;
        data2 = 16'h2222; dest2 = 3'd7;
        do_reset("wrap");
        tag0 = 4'd1; tag1 = 4'd2; tag2 = 4'd3;
        req = 3'b111;
        repeat (65535) @(posedge CLK);
        @(negedge CLK);
        chk("wrap_cnt_ffff", 32'(bcast_cnt), 32'h0000FFFF);
        $display("wrap cnt=%h", bcast_cnt);
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap_cnt_zero", 32'(bcast_cnt), 32'h0);
        chk("wrap_valid", 32'(cdb_valid), 32'h1);
        $display("wrap cnt=%h valid=%0d", bcast_cnt, cdb_valid);
        @(posedge CLK);
        #2 CLR = 1'b1;
        #1;
        chk_all("midclr", 3'b000, 1'b0, '0, '0, 3'd0, 1'b0, 16'd0);
        $display("midclr ack=%b valid=%0d cnt=%0d", ack, cdb_valid, bcast_cnt);
        @(negedge CLK);
        CLR = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("post_clr_ack", 32'(ack), 32'h1);
        chk("post_clr_cnt", 32'(bcast_cnt), 32'h1);
        $display("post_clr ack=%b cnt=%0d", ack, bcast_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
